// File: rtl/z80_stack_seq_pkg.sv
// rtl/z80_stack_seq_pkg.sv - register select codes, state/op encodings and pair legality check
package z80_stack_seq_pkg;

  typedef logic [3:0] reg_select_t;

  localparam reg_select_t REG_BC = 4'd0;
  localparam reg_select_t REG_DE = 4'd1;
  localparam reg_select_t REG_HL = 4'd2;
  localparam reg_select_t REG_AF = 4'd3;
  localparam reg_select_t REG_IX = 4'd4;
  localparam reg_select_t REG_IY = 4'd5;
  localparam reg_select_t REG_SP = 4'd6;
  localparam reg_select_t REG_PC = 4'd7;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM1,
    ST_MEM2,
    ST_WR_REG,
    ST_WR_SP
  } stack_state_t;

  // Only the six pairs that PUSH/POP can name; SP, PC and single registers are rejected.
  function automatic logic rr_legal(input reg_select_t r);
    case (r)
      REG_BC, REG_DE, REG_HL, REG_AF, REG_IX, REG_IY: rr_legal = 1'b1;
      default:                                         rr_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/z80_stack_seq.sv
// rtl/z80_stack_seq.sv - PUSH rr / POP rr sequencer between register file and byte memory
module z80_stack_seq
  import z80_stack_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  reg_select_t rr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output reg_select_t rf_src1,
  input  logic [15:0] rf_out1,
  output reg_select_t rf_src2,
  input  logic [15:0] rf_out2,
  output logic        rf_write_en,
  output reg_select_t rf_dest,
  output logic [15:0] rf_in,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_ready
);

  stack_state_t state_q, state_d;
  logic         op_q, op_d;
  reg_select_t  rr_q, rr_d;
  logic [15:0]  sp_q, sp_d;
  logic [15:0]  val_q, val_d;
  logic         err_q, err_d;

  logic [15:0]  sp_off;
  logic [15:0]  sp_sum;

  assign sp_sum = sp_q + sp_off;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_PUSH;
      rr_q    <= REG_BC;
      sp_q    <= 16'h0000;
      val_q   <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rr_q    <= rr_d;
      sp_q    <= sp_d;
      val_q   <= val_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rr_d        = rr_q;
    sp_d        = sp_q;
    val_d       = val_q;
    err_d       = 1'b0;
    sp_off      = 16'h0000;
    mem_addr    = 16'h0000;
    mem_wdata   = 8'h00;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    rf_write_en = 1'b0;
    rf_dest     = REG_BC;
    rf_in       = 16'h0000;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (rr_legal(rr)) begin
            op_d    = op;
            rr_d    = rr;
            sp_d    = rf_out2;
            if (op == OP_PUSH) val_d = rf_out1;
            state_d = ST_MEM1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_MEM1: begin
        sp_off    = (op_q == OP_PUSH) ? 16'hFFFF : 16'h0000;
        mem_addr  = sp_sum;
        mem_wr    = (op_q == OP_PUSH);
        mem_rd    = (op_q == OP_POP);
        mem_wdata = val_q[15:8];
        if (mem_ready) begin
          if (op_q == OP_POP) val_d[7:0] = mem_rdata;
          state_d = ST_MEM2;
        end
      end
      ST_MEM2: begin
        sp_off    = (op_q == OP_PUSH) ? 16'hFFFE : 16'h0001;
        mem_addr  = sp_sum;
        mem_wr    = (op_q == OP_PUSH);
        mem_rd    = (op_q == OP_POP);
        mem_wdata = val_q[7:0];
        if (mem_ready) begin
          if (op_q == OP_POP) begin
            val_d[15:8] = mem_rdata;
            state_d     = ST_WR_REG;
          end else begin
            state_d = ST_WR_SP;
          end
        end
      end
      ST_WR_REG: begin
        rf_write_en = 1'b1;
        rf_dest     = rr_q;
        rf_in       = val_q;
        state_d     = ST_WR_SP;
      end
      ST_WR_SP: begin
        sp_off      = (op_q == OP_PUSH) ? 16'hFFFE : 16'h0002;
        rf_write_en = 1'b1;
        rf_dest     = REG_SP;
        rf_in       = sp_sum;
        done        = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign err     = err_q;
  assign rf_src1 = rr;
  assign rf_src2 = REG_SP;

endmodule

// File: tb/tb_z80_stack_seq.sv
// tb/tb_z80_stack_seq.sv - randomized PUSH/POP bench with register-file and memory model
module tb_z80_stack_seq;
  import z80_stack_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, op, mem_ready;
  reg_select_t rr;
  logic        busy, done, err, rf_write_en, mem_rd, mem_wr;
  reg_select_t rf_src1, rf_src2, rf_dest;
  logic [15:0] rf_out1, rf_out2, rf_in, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [15:0] regs [0:15];
  logic [7:0]  mem  [0:65535];
  int          acc_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  reg_select_t legal [0:5] = '{REG_BC, REG_DE, REG_HL, REG_AF, REG_IX, REG_IY};

  z80_stack_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rr(rr),
    .busy(busy), .done(done), .err(err),
    .rf_src1(rf_src1), .rf_out1(rf_out1), .rf_src2(rf_src2), .rf_out2(rf_out2),
    .rf_write_en(rf_write_en), .rf_dest(rf_dest), .rf_in(rf_in),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  assign rf_out1   = regs[rf_src1];
  assign rf_out2   = regs[rf_src2];
  assign mem_rdata = mem[mem_addr];

  // Register file and memory commit on the same edge the sequencer completes a transfer.
  always @(posedge clk) begin
    if (!reset) begin
      if (mem_wr && mem_ready) mem[mem_addr] = mem_wdata;
      if (rf_write_en) regs[rf_dest] = rf_in;
      if (((mem_wr || mem_rd) && mem_ready) || rf_write_en) acc_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic run_op(input logic o, input reg_select_t r, input bit spam);
    logic [15:0] sp0, v, new_sp, exp_pair;
    logic [15:0] ea [0:1];
    logic [7:0]  ed [0:1];
    int k, waits, n;
    bit got;
    sp0 = regs[REG_SP];
    v   = regs[r];
    if (o == OP_PUSH) begin
      ea[0] = sp0 - 16'd1; ea[1] = sp0 - 16'd2;
      ed[0] = v[15:8];     ed[1] = v[7:0];
      new_sp = sp0 - 16'd2;
      exp_pair = v;
    end else begin
      ea[0] = sp0;         ea[1] = sp0 + 16'd1;
      ed[0] = 8'h00;       ed[1] = 8'h00;
      new_sp = sp0 + 16'd2;
      exp_pair = {mem[ea[1]], mem[ea[0]]};
    end
    k = 0; waits = 0; n = 0; got = 0;
    @(negedge clk);
    start = 1'b1; op = o; rr = r; mem_ready = 1'($urandom);
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (spam) begin
        op = 1'($urandom);
        rr = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      if (mem_wr || mem_rd) begin
        check_eq("mem_dir", {30'd0, mem_wr, mem_rd}, (o == OP_POP) ? 32'd1 : 32'd2);
        check_eq("mem_addr", {16'd0, mem_addr}, {16'd0, ea[k]});
        if (o == OP_PUSH) check_eq("mem_wdata", {24'd0, mem_wdata}, {24'd0, ed[k]});
        mem_ready = 1'($urandom);
        if (mem_ready) k++; else waits++;
      end
      if (done) begin
        got = 1;
        check_eq("latency", n, ((o == OP_POP) ? 4 : 3) + waits);
      end
    end
    if (!got) check_eq("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    start = 1'b0;
    check_eq("idle_after_done", {31'd0, busy}, 32'd0);
    check_eq("sp_after", {16'd0, regs[REG_SP]}, {16'd0, new_sp});
    check_eq("pair_after", {16'd0, regs[r]}, {16'd0, exp_pair});
    if (o == OP_PUSH) begin
      check_eq("stack_hi", {24'd0, mem[ea[0]]}, {24'd0, ed[0]});
      check_eq("stack_lo", {24'd0, mem[ea[1]]}, {24'd0, ed[1]});
    end
  endtask

  task automatic run_illegal(input reg_select_t r);
    int a0;
    a0 = acc_cnt;
    @(negedge clk);
    start = 1'b1; op = 1'($urandom); rr = r;
    @(negedge clk);
    start = 1'b0;
    check_eq("err_pulse", {31'd0, err}, 32'd1);
    check_eq("err_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_eq("err_clear", {31'd0, err}, 32'd0);
    check_eq("err_no_access", acc_cnt, a0);
  endtask

  initial begin
    logic [15:0] sp_save, bc_save, addr_hi;
    reset = 1'b1; start = 1'b0; op = OP_PUSH; rr = REG_HL; mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    check_eq("rst_outs", {26'd0, busy, done, err, mem_rd, mem_wr, rf_write_en}, 32'd0);
    check_eq("rst_addr", {8'd0, mem_addr, mem_wdata}, 32'd0);
    check_eq("rst_rf", {12'd0, rf_dest, rf_in}, 32'd0);
    check_eq("rst_src", {24'd0, rf_src1, rf_src2}, {24'd0, REG_HL, REG_SP});
    reset = 1'b0;

    regs[REG_BC] = 16'h1234; regs[REG_SP] = 16'h8000;
    run_op(OP_PUSH, REG_BC, 0);
    mem[16'h7FFE] = 8'hCD; mem[16'h7FFF] = 8'hAB;
    run_op(OP_POP, REG_DE, 0);
    check_eq("pop_de_val", {16'd0, regs[REG_DE]}, 32'h0000ABCD);
    regs[REG_HL] = 16'hBEEF; regs[REG_SP] = 16'h0000;
    run_op(OP_PUSH, REG_HL, 0);
    check_eq("push_wrap_ffff", {24'd0, mem[16'hFFFF]}, 32'hBE);
    regs[REG_SP] = 16'hFFFF; mem[16'hFFFF] = 8'h55; mem[16'h0000] = 8'hAA;
    run_op(OP_POP, REG_AF, 0);
    check_eq("pop_af_val", {16'd0, regs[REG_AF]}, 32'h0000AA55);
    check_eq("pop_wrap_sp", {16'd0, regs[REG_SP]}, 32'h00000001);

    run_illegal(REG_SP);
    run_illegal(4'(8 + $urandom_range(0, 7)));

    // Reset while the second push byte is pending: first byte stays, SP stays.
    regs[REG_SP] = 16'h4000; sp_save = 16'h4000; bc_save = regs[REG_BC];
    addr_hi = sp_save - 16'd1;
    @(negedge clk);
    start = 1'b1; op = OP_PUSH; rr = REG_BC; mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("mid_in_mem2", {15'd0, mem_wr, mem_addr}, {15'd0, 1'b1, sp_save - 16'd2});
    reset = 1'b1;
    #1;
    check_eq("mid_rst_outs", {26'd0, busy, done, err, mem_rd, mem_wr, rf_write_en}, 32'd0);
    check_eq("mid_rst_addr", {8'd0, mem_addr, mem_wdata}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_sp_kept", {16'd0, regs[REG_SP]}, {16'd0, sp_save});
    check_eq("mid_hi_byte", {24'd0, mem[addr_hi]}, {24'd0, bc_save[15:8]});

    for (int t = 0; t < 60; t++) begin
      if (t % 5 == 0) regs[REG_SP] = 16'($urandom);
      regs[legal[t % 6]] = 16'($urandom);
      run_op(1'($urandom), legal[$urandom_range(0, 5)], (t % 3) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z80_stack_seq.md
# z80_stack_seq

Sequencer for the Z80 PUSH rr / POP rr data movement, acting as a client of the `registers` block's read and write ports. It sits between the instruction decoder and the memory byte interface. It reads a 16-bit pair and SP from the register file and writes two bytes to the stack, or reads two bytes and writes them back to a register pair. It then updates SP through the register file's single write port.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request; sampled only while idle.
- op  in  1  0 = PUSH, 1 = POP.
- rr  in  `reg_select  pair select; legal values are REG_BC, REG_DE, REG_HL, REG_AF, REG_IX and REG_IY.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse; asserted in the final (SP write) cycle.
- err  out  1  one-cycle pulse, asserted the cycle after a start with an illegal rr.
- rf_src1  out  `reg_select  register-file read select for the pair.
- rf_out1  in  16  pair value, combinational from the register file.
- rf_src2  out  `reg_select  constant REG_SP.
- rf_out2  in  16  SP value.
- rf_write_en  out  1  register-file write strobe.
- rf_dest  out  `reg_select  write destination.
- rf_in  out  16  write data.
- mem_addr  out  16  byte address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte; valid when mem_ready is high.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- mem_ready  in  1  transfer completes at a posedge where mem_ready is high and a request is active.

## Operation
- States: IDLE, MEM1, MEM2, WR_REG, WR_SP.
- IDLE
  - rf_src1 = rr; rf_src2 = REG_SP.
  - On start with a legal rr: latch op, rr, sp = rf_out2 and val = rf_out1 (PUSH only), then go to MEM1.
  - On start with an illegal rr: pulse err, stay in IDLE, make no memory or register access.
- PUSH
  - MEM1: mem_wr = 1, mem_addr = sp−1, mem_wdata = val[15:8].
  - MEM2: mem_wr = 1, mem_addr = sp−2, mem_wdata = val[7:0].
  - WR_SP: rf_dest = REG_SP, rf_in = sp−2.
- POP
  - MEM1: mem_rd = 1, mem_addr = sp; capture the low byte.
  - MEM2: mem_rd = 1, mem_addr = sp+1; capture the high byte.
  - WR_REG: rf_dest = rr, rf_in = {hi, lo}.
  - WR_SP: rf_dest = REG_SP, rf_in = sp+2.
- Each MEM state holds its request, address and data stable until mem_ready is sampled high, then advances.
- rf_write_en is high only in WR_REG and WR_SP. WR_SP asserts done and returns to IDLE.
- Address arithmetic is modulo 2^16.
  - PUSH at SP = 0x0000 writes 0xFFFF then 0xFFFE; new SP = 0xFFFE.
  - POP at SP = 0xFFFF reads 0xFFFF then 0x0000; new SP = 0x0001.
- POP AF writes F through the AF path. The register file gives AF writes priority over f_wr, so no extra interlock is needed here.

## Timing
- Reset values:
  - state IDLE.
  - busy, done, err, mem_rd, mem_wr and rf_write_en all 0.
  - mem_addr, mem_wdata, rf_in and rf_dest 0.
  - rf_src1 = rr; rf_src2 = REG_SP.
- Minimum latency from the start edge to done, with zero memory wait: PUSH 3 cycles, POP 4 cycles. Each cycle with mem_ready low adds one cycle.
- start while busy is ignored and never queued.
- A start in the done cycle is ignored. The next start is accepted in the following IDLE cycle, so it sees the updated SP.
- Reset mid-operation:
  - Return to IDLE immediately and drop all requests.
  - Any half-written stack bytes remain in memory; SP is not updated.
- Latched sp and val are immune to changes on rf_out1 and rf_out2 after the start cycle.

## Structure
- State encoding and the op encoding constants (OP_PUSH, OP_POP) go in z80.vh alongside `reg_select and the REG_* codes.
- Legality check on rr: a small function in the same header, reusable by the decoder.
- Single module; no sub-module is natural.
- SP ± 1 and ± 2 come from one adder with a muxed offset.

## Test plan
- PUSH BC, with BC = 0x1234, SP = 0x8000 and mem_ready tied high -> writes 0x7FFF ← 0x12, then 0x7FFE ← 0x34. SP becomes 0x7FFE; done 3 cycles after start.
- POP DE, with memory 0x7FFE = 0xCD, 0x7FFF = 0xAB and SP = 0x7FFE -> DE = 0xABCD, SP = 0x8000, done 4 cycles after start.
- PUSH HL, with HL = 0xBEEF, SP = 0x0000 -> writes 0xFFFF ← 0xBE, then 0xFFFE ← 0xEF; SP = 0xFFFE.
- POP AF at SP = 0xFFFF, with memory 0xFFFF = 0x55, 0x0000 = 0xAA -> AF = 0xAA55 (reg_f = 0x55), SP = 0x0001.
- mem_ready held low for 2 cycles in MEM1 of PUSH IX -> address and data held stable; done arrives 2 cycles late.
- Edge cases:
  - Start with rr = REG_SP -> err pulse and no accesses.
  - Start while busy -> ignored.
  - Reset asserted in MEM2 -> all outputs 0 and state IDLE; SP unchanged.
